// File: rtl/arc_mem_pkg.sv
// Shared definitions for the main-memory arbiter: FSM state encoding and default widths.
package arc_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int ARC_AW = 32;
  localparam int ARC_DW = 32;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational priority picker: scans requests starting at i_ptr, wrapping modulo NREQ,
// and returns a one-hot grant for the first active request plus a valid flag.
module arb_priority_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic            o_valid
);

  // Scan from the farthest offset down so the nearest active request overwrites the rest.
  always_comb begin
    o_grant = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_grant = '0;
        o_grant[(int'(i_ptr) + k) % NREQ] = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/mem_access_arbiter.sv
// Single-port main-memory arbiter: one transaction at a time, registered memory strobes.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest index always wins.
module mem_access_arbiter
  import arc_mem_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = ARC_AW,
  parameter int DW   = ARC_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [AW-1:0]      mem_address,
  output logic [DW-1:0]      mem_data_in,
  output logic               mem_rd,
  output logic               mem_wr,
  input  logic [DW-1:0]      mem_data_out
);

  localparam int PW = idx_width(NREQ);

  logic [1:0]      r_state;
  logic [PW-1:0]   r_idx;
  logic            r_we;
  logic [NREQ-1:0] r_ack;
  logic [DW-1:0]   r_rdata;
  logic            r_busy;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_din;
  logic            r_rd;
  logic            r_wr;

  logic [NREQ-1:0] w_grant;
  logic            w_valid;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_ptr;
  logic [AW-1:0]   w_addr_arr  [NREQ];
  logic [DW-1:0]   w_wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = addr[gi*AW +: AW];
    assign w_wdata_arr[gi] = wdata[gi*DW +: DW];
  end

  arb_priority_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_idx = PW'(i);
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [PW-1:0] r_ptr;

  // The granted port drops to lowest priority for the next arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_state == ST_IDLE && w_valid) begin
      r_ptr <= PW'((int'(w_idx) + 1) % NREQ);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_ack <= '0;
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_idx   <= w_idx;
            r_we    <= we[w_idx];
            r_addr  <= w_addr_arr[w_idx];
            r_din   <= w_wdata_arr[w_idx];
            r_rd    <= ~we[w_idx];
            r_wr    <= we[w_idx];
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Writes need no data phase, so they acknowledge straight away.
          if (r_we) begin
            r_ack[r_idx] <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_rdata      <= mem_data_out;
          r_ack[r_idx] <= 1'b1;
          r_state      <= ST_RESP;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign busy        = r_busy;
  assign mem_address = r_addr;
  assign mem_data_in = r_din;
  assign mem_rd      = r_rd;
  assign mem_wr      = r_wr;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomised self-checking bench for mem_access_arbiter against a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN when predicting the arbitration winner.
module tb_mem_access_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [AW-1:0]      mem_address;
  logic [DW-1:0]      mem_data_in;
  logic               mem_rd;
  logic               mem_wr;
  logic [DW-1:0]      mem_data_out;

  always #5 clk = ~clk;

  mem_access_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .ack          (ack),
    .rdata        (rdata),
    .busy         (busy),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_data_out (mem_data_out)
  );

  // Synchronous-read memory attached to the arbiter.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_address[11:2]] <= mem_data_in;
    if (mem_rd) mem_data_out <= mem[mem_address[11:2]];
  end

  // Reference model state: expected memory contents and arbitration pointer.
  logic [31:0] ref_mem [0:1023];
  int ptr_m;
  int n_cmp = 0;
  int n_bad = 0;
  int overlap_cnt = 0;

  always @(negedge clk) if (mem_rd && mem_wr) overlap_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int predict(input logic [NREQ-1:0] pend);
    for (int off = 0; off < NREQ; off++) begin
      if (pend[(ptr_m + off) % NREQ]) return (ptr_m + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_port(input int p, input bit w, input int word, input logic [31:0] d);
    req[p]            = 1'b1;
    we[p]             = w;
    addr[p*AW +: AW]  = word * 4;
    wdata[p*DW +: DW] = d;
  endtask

  // Caller sets req at a negedge; cycle 0 (the granting IDLE) is 'base' cycles later.
  task automatic await_ack(input string tag, input int base, output int won);
    int p, ack_k, rd_cnt, wr_cnt, rd_first, wr_first, idle_cnt;
    logic is_wr;
    logic [31:0] a, d, exp_d;
    p = predict(req);
    won = p;
    if (p < 0) begin
      chk({tag, "_nopend"}, 0, 1);
      return;
    end
    is_wr = we[p];
    a     = addr[p*AW +: AW];
    d     = wdata[p*DW +: DW];
    exp_d = ref_mem[a[11:2]];
    if (RR) ptr_m = (p + 1) % NREQ;
    ack_k = -1; rd_cnt = 0; wr_cnt = 0; rd_first = -1; wr_first = -1; idle_cnt = 0;
    for (int k = 1; k <= base + 12; k++) begin
      @(negedge clk);
      if (mem_rd) begin rd_cnt++; if (rd_first < 0) rd_first = k; end
      if (mem_wr) begin wr_cnt++; if (wr_first < 0) wr_first = k; end
      if (!busy) idle_cnt++;
      if (ack != '0) begin ack_k = k; break; end
    end
    if (ack_k < 0) begin
      chk({tag, "_timeout"}, 0, 1);
      won = -1;
      return;
    end
    chk({tag, "_lat"}, ack_k, base + (is_wr ? 2 : 3));
    chk({tag, "_ack"}, ack, 64'(1) << p);
    chk({tag, "_rdwr"}, rd_cnt * 16 + wr_cnt, is_wr ? 1 : 16);
    chk({tag, "_strobe_cyc"}, is_wr ? wr_first : rd_first, base + 1);
    chk({tag, "_idle"}, idle_cnt, base);
    if (is_wr) ref_mem[a[11:2]] = d;
    else chk({tag, "_rdata"}, rdata, exp_d);
    $display("txn %s: port %0d %s addr 0x%0h data 0x%0h ack at +%0d",
             tag, p, is_wr ? "wr" : "rd", a, is_wr ? d : rdata, ack_k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [NREQ-1:0] pend;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    mem[524] = 32'h14;  ref_mem[524] = 32'h14;
    mem[525] = 32'h838; ref_mem[525] = 32'h838;
    mem_data_out = '0;
    ptr_m = 0;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdwr", {mem_rd, mem_wr}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_din", mem_data_in, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: port0 read 2096
    set_port(0, 1'b0, 524, 32'h0);
    await_ack("t1", 0, w);
    chk("t1_value", rdata, 32'h14);
    req = '0;

    // 2: port1 write then read 2104
    set_port(1, 1'b1, 526, 32'hDEADBEEF);
    await_ack("t2w", 1, w);
    set_port(1, 1'b0, 526, 32'h0);
    await_ack("t2r", 1, w);
    chk("t2_value", rdata, 32'hDEADBEEF);
    req = '0;

    // 3: both ports hold read requests
    set_port(0, 1'b0, 524, 32'h0);
    set_port(1, 1'b0, 525, 32'h0);
    for (int i = 0; i < 4; i++) begin
      await_ack("t3", 1, w);
      chk("t3_winner", w, RR ? (i % 2) : 0);
    end
    req = '0;

    // 4: reset during the WAIT of a port0 read
    set_port(0, 1'b0, 524, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1; req = '0;
    @(negedge clk);
    ptr_m = 0;
    chk("t4_ack", ack, 0);
    chk("t4_busy", busy, 0);
    chk("t4_rdwr", {mem_rd, mem_wr}, 0);
    chk("t4_addr", mem_address, 0);
    chk("t4_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_noack", ack, 0);
    chk("t4_idle", busy, 0);
    set_port(0, 1'b0, 525, 32'h0);
    await_ack("t4r", 0, w);
    req = '0;

    // 5: port0 drops req in ISSUE, port1 requests in WAIT
    set_port(0, 1'b0, 524, 32'h0);
    if (RR) ptr_m = 1;
    @(negedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    set_port(1, 1'b0, 525, 32'h0);
    @(negedge clk);
    chk("t5_ack0", ack, 2'b01);
    chk("t5_rdata0", rdata, 32'h14);
    await_ack("t5p1", 1, w);
    chk("t5_winner", w, 1);
    req = '0;

    // 6: back-to-back port0 reads; one idle cycle each
    set_port(0, 1'b0, 524, 32'h0);
    for (int i = 0; i < 4; i++) await_ack("t6", 1, w);

    // Random traffic: acked port retires or re-requests; others keep holding.
    for (int n = 0; n < 60; n++) begin
      if (w >= 0 && $urandom_range(0, 1) == 1) set_port(w, 1'($urandom_range(0, 1)),
                                                      int'($urandom_range(520, 531)), $urandom);
      else if (w >= 0) req[w] = 1'b0;
      for (int p = 0; p < NREQ; p++) begin
        if (!req[p] && $urandom_range(0, 3) == 0)
          set_port(p, 1'($urandom_range(0, 1)), int'($urandom_range(520, 531)), $urandom);
      end
      if (req == '0) begin
        pend = 2'($urandom_range(1, 3));
        for (int p = 0; p < NREQ; p++)
          if (pend[p]) set_port(p, 1'($urandom_range(0, 1)), int'($urandom_range(520, 531)), $urandom);
      end
      await_ack("rnd", 1, w);
      if (w < 0) break;
    end
    req = '0;
    repeat (3) @(negedge clk);
    chk("rdwr_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
